// File: rtl/tl_requester_if.sv
// Command, write-data, TileLink A/D and response streams of the TL-UH requester.
// master is the requester's view; slave is the engine/interconnect side.
interface tl_requester_if #(
    parameter int unsigned TL_RS = 1,
    parameter int unsigned TL_AW = 32,
    parameter int unsigned TL_DW = 32
);
    logic                 tlreq_cmd_valid;
    logic                 tlreq_cmd_ready;
    logic                 tlreq_cmd_write;
    logic [3:0]           tlreq_cmd_size;
    logic [TL_AW-1:0]     tlreq_cmd_address;
    logic [TL_DW/8-1:0]   tlreq_cmd_mask;

    logic [TL_DW-1:0]     tlreq_wr_data;
    logic                 tlreq_wr_valid;
    logic                 tlreq_wr_ready;

    logic [2:0]           tlreq_a_opcode;
    logic [2:0]           tlreq_a_param;
    logic [3:0]           tlreq_a_size;
    logic [TL_RS-1:0]     tlreq_a_source;
    logic [TL_AW-1:0]     tlreq_a_address;
    logic [TL_DW/8-1:0]   tlreq_a_mask;
    logic [TL_DW-1:0]     tlreq_a_data;
    logic                 tlreq_a_corrupt;
    logic                 tlreq_a_valid;
    logic                 tlreq_a_ready;

    logic [2:0]           tlreq_d_opcode;
    logic [1:0]           tlreq_d_param;
    logic [3:0]           tlreq_d_size;
    logic [TL_RS-1:0]     tlreq_d_source;
    logic                 tlreq_d_denied;
    logic [TL_DW-1:0]     tlreq_d_data;
    logic                 tlreq_d_corrupt;
    logic                 tlreq_d_valid;
    logic                 tlreq_d_ready;

    logic [TL_DW-1:0]     tlreq_rsp_data;
    logic                 tlreq_rsp_last;
    logic                 tlreq_rsp_denied;
    logic                 tlreq_rsp_corrupt;
    logic                 tlreq_rsp_valid;
    logic                 tlreq_rsp_ready;

    modport master (
        input  tlreq_cmd_valid, tlreq_cmd_write, tlreq_cmd_size, tlreq_cmd_address,
               tlreq_cmd_mask, tlreq_wr_data, tlreq_wr_valid, tlreq_a_ready,
               tlreq_d_opcode, tlreq_d_param, tlreq_d_size, tlreq_d_source, tlreq_d_denied,
               tlreq_d_data, tlreq_d_corrupt, tlreq_d_valid, tlreq_rsp_ready,
        output tlreq_cmd_ready, tlreq_wr_ready, tlreq_a_opcode, tlreq_a_param, tlreq_a_size,
               tlreq_a_source, tlreq_a_address, tlreq_a_mask, tlreq_a_data, tlreq_a_corrupt,
               tlreq_a_valid, tlreq_d_ready, tlreq_rsp_data, tlreq_rsp_last,
               tlreq_rsp_denied, tlreq_rsp_corrupt, tlreq_rsp_valid
    );

    modport slave (
        output tlreq_cmd_valid, tlreq_cmd_write, tlreq_cmd_size, tlreq_cmd_address,
               tlreq_cmd_mask, tlreq_wr_data, tlreq_wr_valid, tlreq_a_ready,
               tlreq_d_opcode, tlreq_d_param, tlreq_d_size, tlreq_d_source, tlreq_d_denied,
               tlreq_d_data, tlreq_d_corrupt, tlreq_d_valid, tlreq_rsp_ready,
        input  tlreq_cmd_ready, tlreq_wr_ready, tlreq_a_opcode, tlreq_a_param, tlreq_a_size,
               tlreq_a_source, tlreq_a_address, tlreq_a_mask, tlreq_a_data, tlreq_a_corrupt,
               tlreq_a_valid, tlreq_d_ready, tlreq_rsp_data, tlreq_rsp_last,
               tlreq_rsp_denied, tlreq_rsp_corrupt, tlreq_rsp_valid
    );
endinterface

// File: rtl/tl_requester.sv
// Single-outstanding TL-UH initiator: command stream in, Get/PutFull/PutPartial out on A,
// D responses forwarded onto the response stream; sticky command/protocol error flags.
module tl_requester #(
    parameter int unsigned TL_RS     = 1,
    parameter int unsigned TL_AW     = 32,
    parameter int unsigned TL_DW     = 32,
    parameter int unsigned SOURCE_ID = 0
) (
    input  logic            tlreq_clock_i,
    input  logic            tlreq_reset_i,
    tl_requester_if.master  bus,
    output logic            tlreq_cmd_err_o,
    output logic            tlreq_proto_err_o
);
    localparam int unsigned LB = $clog2(TL_DW / 8);
    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACTIVE = 1'b1;

    logic [0:0]         st_q, st_d;
    logic               write_q, write_d;
    logic               multi_q, multi_d;
    logic [3:0]         size_q, size_d;
    logic [TL_AW-1:0]   addr_q, addr_d;
    logic [TL_DW/8-1:0] mask_q, mask_d;
    logic [11:0]        a_left_q, a_left_d;
    logic [11:0]        d_left_q, d_left_d;
    logic               cmd_err_q, cmd_err_d;
    logic               proto_err_q, proto_err_d;

    logic        active, a_go, d_go, d_ok, a_hs, d_hs;
    logic [11:0] n_beats;

    assign active = (st_q == ACTIVE);
    assign a_go   = active && (a_left_q != 12'd0);
    assign d_go   = active && (d_left_q != 12'd0);
    // Only a beat of the expected source/opcode inside the response window is forwarded.
    assign d_ok   = d_go && (bus.tlreq_d_source == TL_RS'(SOURCE_ID)) &&
                    (bus.tlreq_d_opcode == (write_q ? 3'd0 : 3'd1));

    assign bus.tlreq_cmd_ready   = !active;
    assign bus.tlreq_a_valid     = a_go && (write_q ? bus.tlreq_wr_valid : 1'b1);
    assign bus.tlreq_wr_ready    = a_go && write_q && bus.tlreq_a_ready;
    assign bus.tlreq_a_opcode    = write_q ? ((multi_q || (&mask_q)) ? 3'd0 : 3'd1) : 3'd4;
    assign bus.tlreq_a_param     = 3'd0;
    assign bus.tlreq_a_size      = size_q;
    assign bus.tlreq_a_source    = TL_RS'(SOURCE_ID);
    assign bus.tlreq_a_address   = addr_q;
    assign bus.tlreq_a_mask      = multi_q ? {(TL_DW/8){1'b1}} : mask_q;
    assign bus.tlreq_a_data      = write_q ? bus.tlreq_wr_data : '0;
    assign bus.tlreq_a_corrupt   = 1'b0;

    assign bus.tlreq_d_ready     = d_go ? bus.tlreq_rsp_ready : 1'b1;
    assign bus.tlreq_rsp_valid   = bus.tlreq_d_valid && d_ok;
    assign bus.tlreq_rsp_data    = write_q ? '0 : bus.tlreq_d_data;
    assign bus.tlreq_rsp_last    = (d_left_q == 12'd1);
    assign bus.tlreq_rsp_denied  = bus.tlreq_d_denied;
    assign bus.tlreq_rsp_corrupt = bus.tlreq_d_corrupt;

    assign a_hs = bus.tlreq_a_valid && bus.tlreq_a_ready;
    assign d_hs = bus.tlreq_d_valid && bus.tlreq_d_ready;

    assign tlreq_cmd_err_o   = cmd_err_q;
    assign tlreq_proto_err_o = proto_err_q;

    always_comb begin
        if (bus.tlreq_cmd_size <= 4'(LB)) begin
            n_beats = 12'd1;
        end else begin
            n_beats = 12'd1 << (bus.tlreq_cmd_size - 4'(LB));
        end
    end

    always_comb begin
        st_d        = st_q;
        write_d     = write_q;
        multi_d     = multi_q;
        size_d      = size_q;
        addr_d      = addr_q;
        mask_d      = mask_q;
        a_left_d    = a_left_q;
        d_left_d    = d_left_q;
        cmd_err_d   = cmd_err_q;
        proto_err_d = proto_err_q;
        if (!active) begin
            if (bus.tlreq_cmd_valid) begin
                if (bus.tlreq_cmd_size > 4'd12) begin
                    cmd_err_d = 1'b1;
                end else begin
                    write_d  = bus.tlreq_cmd_write;
                    multi_d  = (n_beats != 12'd1);
                    size_d   = bus.tlreq_cmd_size;
                    addr_d   = bus.tlreq_cmd_address;
                    mask_d   = bus.tlreq_cmd_mask;
                    a_left_d = bus.tlreq_cmd_write ? n_beats : 12'd1;
                    d_left_d = bus.tlreq_cmd_write ? 12'd1 : n_beats;
                    st_d     = ACTIVE;
                end
            end
        end else begin
            a_left_d = a_left_q - {11'd0, a_hs};
            d_left_d = d_left_q - {11'd0, d_hs && d_ok};
            if ((a_left_d == 12'd0) && (d_left_d == 12'd0)) begin
                st_d = IDLE;
            end
        end
        if (d_hs && !d_ok) begin
            proto_err_d = 1'b1;
        end
    end

    always_ff @(posedge tlreq_clock_i or negedge tlreq_reset_i) begin
        if (!tlreq_reset_i) begin
            st_q        <= IDLE;
            write_q     <= 1'b0;
            multi_q     <= 1'b0;
            size_q      <= 4'd0;
            addr_q      <= '0;
            mask_q      <= '0;
            a_left_q    <= 12'd0;
            d_left_q    <= 12'd0;
            cmd_err_q   <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            st_q        <= st_d;
            write_q     <= write_d;
            multi_q     <= multi_d;
            size_q      <= size_d;
            addr_q      <= addr_d;
            mask_q      <= mask_d;
            a_left_q    <= a_left_d;
            d_left_q    <= d_left_d;
            cmd_err_q   <= cmd_err_d;
            proto_err_q <= proto_err_d;
        end
    end
endmodule

// File: tb/tb_tl_requester.sv
// Self-checking bench for tl_requester: directed scenarios plus randomized transactions
// checked against a transaction-level model of expected A beats and response beats.
module tb_tl_requester;
    localparam int unsigned TL_RS     = 1;
    localparam int unsigned TL_AW     = 32;
    localparam int unsigned TL_DW     = 32;
    localparam int unsigned SOURCE_ID = 0;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic cmd_err, proto_err;
    int   vectors    = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    tl_requester_if #(.TL_RS(TL_RS), .TL_AW(TL_AW), .TL_DW(TL_DW)) bus ();

    tl_requester #(
        .TL_RS(TL_RS), .TL_AW(TL_AW), .TL_DW(TL_DW), .SOURCE_ID(SOURCE_ID)
    ) dut (
        .tlreq_clock_i    (clk),
        .tlreq_reset_i    (rst_n),
        .bus              (bus.master),
        .tlreq_cmd_err_o  (cmd_err),
        .tlreq_proto_err_o(proto_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit rnd(input int pct);
        return $urandom_range(0, 99) < pct;
    endfunction

    task automatic idle_in();
        bus.tlreq_cmd_valid   = 1'b0;
        bus.tlreq_cmd_write   = 1'b0;
        bus.tlreq_cmd_size    = 4'd0;
        bus.tlreq_cmd_address = '0;
        bus.tlreq_cmd_mask    = '0;
        bus.tlreq_wr_data     = '0;
        bus.tlreq_wr_valid    = 1'b0;
        bus.tlreq_a_ready     = 1'b1;
        bus.tlreq_d_opcode    = 3'd0;
        bus.tlreq_d_param     = 2'd0;
        bus.tlreq_d_size      = 4'd0;
        bus.tlreq_d_source    = '0;
        bus.tlreq_d_denied    = 1'b0;
        bus.tlreq_d_data      = '0;
        bus.tlreq_d_corrupt   = 1'b0;
        bus.tlreq_d_valid     = 1'b0;
        bus.tlreq_rsp_ready   = 1'b1;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_cmd_ready"}, 32'(bus.tlreq_cmd_ready), 32'd1);
        chk({tag, "_a_valid"},   32'(bus.tlreq_a_valid),   32'd0);
        chk({tag, "_wr_ready"},  32'(bus.tlreq_wr_ready),  32'd0);
        chk({tag, "_d_ready"},   32'(bus.tlreq_d_ready),   32'd1);
        chk({tag, "_rsp_valid"}, 32'(bus.tlreq_rsp_valid), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_in();
        #1;
        chk_idle_outputs("rst");
        chk("rst_cmd_err",   32'(cmd_err),   32'd0);
        chk("rst_proto_err", 32'(proto_err), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic issue_cmd(input bit wr, input logic [3:0] sz, input logic [31:0] addr,
                             input logic [3:0] mask);
        bus.tlreq_cmd_valid   = 1'b1;
        bus.tlreq_cmd_write   = wr;
        bus.tlreq_cmd_size    = sz;
        bus.tlreq_cmd_address = addr;
        bus.tlreq_cmd_mask    = mask;
        #1;
        chk("cmd_ready", 32'(bus.tlreq_cmd_ready), 32'd1);
        tick();
        bus.tlreq_cmd_valid = 1'b0;
    endtask

    // Runs one full transaction with random handshake stalls. Nonzero dbase makes data
    // directed: Get responses dbase+i, Put beats alternate dbase / ~dbase.
    task automatic run_txn(input bit wr, input logic [3:0] sz, input logic [31:0] addr,
                           input logic [3:0] mask, input logic [31:0] dbase,
                           input bit den, input bit cor, input int pct);
        int n, a_total, r_total, a_sent, d_sent, r_got, cyc, budget;
        bit d_pend, first, a_hs, d_hs;
        logic [31:0] wq[$];
        logic [31:0] rq[$];
        logic [2:0]  exp_op;
        logic [3:0]  exp_mask;
        n       = (sz <= 4'd2) ? 1 : (1 << (int'(sz) - 2));
        a_total = wr ? n : 1;
        r_total = wr ? 1 : n;
        for (int i = 0; i < a_total; i++) begin
            wq.push_back((dbase == 0) ? $urandom : ((i % 2 == 0) ? dbase : ~dbase));
        end
        for (int i = 0; i < r_total; i++) begin
            rq.push_back(wr ? 32'd0 : ((dbase == 0) ? $urandom : dbase + 32'(i)));
        end
        exp_op   = wr ? (((n > 1) || (mask == 4'hF)) ? 3'd0 : 3'd1) : 3'd4;
        exp_mask = (n > 1) ? 4'hF : mask;
        budget   = 20 * (a_total + r_total) + 100;
        a_sent = 0; d_sent = 0; r_got = 0; cyc = 0; d_pend = 0; first = 1;

        issue_cmd(wr, sz, addr, mask);
        while ((a_sent < a_total || r_got < r_total) && cyc < budget) begin
            bus.tlreq_a_ready   = rnd(pct);
            bus.tlreq_rsp_ready = rnd(pct);
            if (wr && a_sent < a_total) begin
                bus.tlreq_wr_valid = rnd(pct);
                bus.tlreq_wr_data  = wq[a_sent];
            end else begin
                bus.tlreq_wr_valid = 1'b0;
            end
            if (!d_pend && d_sent < r_total && a_sent > 0 && rnd(pct)) begin
                d_pend               = 1'b1;
                bus.tlreq_d_opcode   = wr ? 3'd0 : 3'd1;
                bus.tlreq_d_source   = TL_RS'(SOURCE_ID);
                bus.tlreq_d_data     = wr ? $urandom : rq[d_sent];
                bus.tlreq_d_denied   = den;
                bus.tlreq_d_corrupt  = cor;
            end
            bus.tlreq_d_valid = d_pend;
            #1;
            if (first) begin
                chk("a_first", 32'(bus.tlreq_a_valid), wr ? 32'(bus.tlreq_wr_valid) : 32'd1);
                first = 0;
            end
            if (wr) begin
                chk("wr_ready", 32'(bus.tlreq_wr_ready),
                    32'((a_sent < a_total) && bus.tlreq_a_ready));
            end
            if (bus.tlreq_a_valid) begin
                chk("a_opcode",  32'(bus.tlreq_a_opcode),  32'(exp_op));
                chk("a_size",    32'(bus.tlreq_a_size),    32'(sz));
                chk("a_address", bus.tlreq_a_address,      addr);
                chk("a_mask",    32'(bus.tlreq_a_mask),    32'(exp_mask));
                chk("a_source",  32'(bus.tlreq_a_source),  SOURCE_ID);
                chk("a_param",   32'(bus.tlreq_a_param),   32'd0);
                chk("a_corrupt", 32'(bus.tlreq_a_corrupt), 32'd0);
                if (wr) chk("a_data", bus.tlreq_a_data, wq[a_sent]);
            end
            if (bus.tlreq_d_valid) begin
                chk("d_ready",   32'(bus.tlreq_d_ready),   32'(bus.tlreq_rsp_ready));
                chk("rsp_valid", 32'(bus.tlreq_rsp_valid), 32'd1);
                if (bus.tlreq_rsp_ready) begin
                    chk("rsp_data",    bus.tlreq_rsp_data,          rq[r_got]);
                    chk("rsp_last",    32'(bus.tlreq_rsp_last),    32'(r_got == r_total - 1));
                    chk("rsp_denied",  32'(bus.tlreq_rsp_denied),  32'(den));
                    chk("rsp_corrupt", 32'(bus.tlreq_rsp_corrupt), 32'(cor));
                end
            end
            a_hs = bus.tlreq_a_valid && bus.tlreq_a_ready;
            d_hs = bus.tlreq_d_valid && bus.tlreq_d_ready;
            tick();
            if (a_hs) a_sent++;
            if (d_hs) begin
                d_pend = 0;
                d_sent++;
                r_got++;
            end
            cyc++;
        end
        chk("txn_done", 32'((a_sent == a_total) && (r_got == r_total)), 32'd1);
        idle_in();
        #1;
        chk("back_to_idle_cmd_ready", 32'(bus.tlreq_cmd_ready), 32'd1);
        chk("back_to_idle_a_valid",   32'(bus.tlreq_a_valid),   32'd0);
        chk("txn_proto_err",          32'(proto_err),           32'd0);
        tick();
    endtask

    initial begin
        idle_in();
        do_reset();

        run_txn(1'b0, 4'd2, 32'h100, 4'hF, 32'hDEADBEEF, 1'b0, 1'b0, 100);
        run_txn(1'b0, 4'd4, 32'h200, 4'hF, 32'd1,        1'b0, 1'b0, 100);
        run_txn(1'b1, 4'd3, 32'h300, 4'hF, 32'hA5A5A5A5, 1'b0, 1'b0, 35);
        run_txn(1'b0, 4'd5, 32'h400, 4'hF, 32'd0,        1'b1, 1'b1, 70);
        run_txn(1'b1, 4'd1, 32'h602, 4'h3, 32'd0,        1'b0, 1'b0, 80);
        run_txn(1'b0, 4'd12, 32'h1000, 4'hF, 32'd0,      1'b0, 1'b0, 100);

        // A stall then response stall on a two-beat Get.
        issue_cmd(1'b0, 4'd3, 32'h500, 4'hF);
        bus.tlreq_a_ready = 1'b0;
        repeat (3) begin
            #1;
            chk("stall_a_valid",   32'(bus.tlreq_a_valid),   32'd1);
            chk("stall_a_opcode",  32'(bus.tlreq_a_opcode),  32'd4);
            chk("stall_a_address", bus.tlreq_a_address,      32'h500);
            chk("stall_a_size",    32'(bus.tlreq_a_size),    32'd3);
            tick();
        end
        bus.tlreq_a_ready = 1'b1;
        #1;
        chk("stall_a_accept", 32'(bus.tlreq_a_valid), 32'd1);
        tick();
        bus.tlreq_a_ready   = 1'b0;
        bus.tlreq_d_valid   = 1'b1;
        bus.tlreq_d_opcode  = 3'd1;
        bus.tlreq_d_data    = 32'h1111;
        bus.tlreq_rsp_ready = 1'b0;
        repeat (3) begin
            #1;
            chk("stall_d_ready",   32'(bus.tlreq_d_ready),   32'd0);
            chk("stall_rsp_valid", 32'(bus.tlreq_rsp_valid), 32'd1);
            chk("stall_no_a",      32'(bus.tlreq_a_valid),   32'd0);
            tick();
        end
        bus.tlreq_rsp_ready = 1'b1;
        #1;
        chk("stall_rsp0_data", bus.tlreq_rsp_data,       32'h1111);
        chk("stall_rsp0_last", 32'(bus.tlreq_rsp_last),  32'd0);
        tick();
        bus.tlreq_d_data = 32'h2222;
        #1;
        chk("stall_rsp1_data", bus.tlreq_rsp_data,       32'h2222);
        chk("stall_rsp1_last", 32'(bus.tlreq_rsp_last),  32'd1);
        tick();
        idle_in();
        #1;
        chk("stall_done", 32'(bus.tlreq_cmd_ready), 32'd1);
        tick();

        repeat (24) begin
            run_txn(1'($urandom_range(0, 1)), 4'($urandom_range(0, 6)), $urandom,
                    4'($urandom), 32'd0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    $urandom_range(30, 100));
        end

        // Wrong-source beat during an expected response window.
        issue_cmd(1'b0, 4'd2, 32'h700, 4'hF);
        #1;
        chk("ws_a_valid", 32'(bus.tlreq_a_valid), 32'd1);
        tick();
        bus.tlreq_d_valid  = 1'b1;
        bus.tlreq_d_opcode = 3'd1;
        bus.tlreq_d_source = 1'b1;
        bus.tlreq_d_data   = 32'h66;
        #1;
        chk("ws_rsp_valid", 32'(bus.tlreq_rsp_valid), 32'd0);
        chk("ws_d_ready",   32'(bus.tlreq_d_ready),   32'd1);
        tick();
        bus.tlreq_d_source = 1'b0;
        bus.tlreq_d_data   = 32'h77;
        #1;
        chk("ws_proto_err", 32'(proto_err),            32'd1);
        chk("ws_rsp_valid2", 32'(bus.tlreq_rsp_valid), 32'd1);
        chk("ws_rsp_data",  bus.tlreq_rsp_data,        32'h77);
        chk("ws_rsp_last",  32'(bus.tlreq_rsp_last),   32'd1);
        tick();
        idle_in();
        #1;
        chk("ws_idle", 32'(bus.tlreq_cmd_ready), 32'd1);
        do_reset();

        // Illegal size: flag only, no bus traffic.
        issue_cmd(1'b0, 4'd13, 32'h800, 4'hF);
        #1;
        chk("sz13_cmd_err", 32'(cmd_err), 32'd1);
        repeat (2) begin
            chk("sz13_no_a", 32'(bus.tlreq_a_valid),   32'd0);
            chk("sz13_idle", 32'(bus.tlreq_cmd_ready), 32'd1);
            tick();
        end

        // D beat while idle.
        bus.tlreq_d_valid  = 1'b1;
        bus.tlreq_d_opcode = 3'd1;
        #1;
        chk("idle_d_ready",   32'(bus.tlreq_d_ready),   32'd1);
        chk("idle_rsp_valid", 32'(bus.tlreq_rsp_valid), 32'd0);
        tick();
        bus.tlreq_d_valid = 1'b0;
        #1;
        chk("idle_proto_err", 32'(proto_err), 32'd1);

        // Reset in the middle of an 8-beat Get.
        issue_cmd(1'b0, 4'd5, 32'h900, 4'hF);
        tick();
        bus.tlreq_d_valid  = 1'b1;
        bus.tlreq_d_opcode = 3'd1;
        #1;
        chk("mid_rsp_valid", 32'(bus.tlreq_rsp_valid), 32'd1);
        tick();
        rst_n = 1'b0;
        #1;
        chk_idle_outputs("mid_rst");
        chk("mid_rst_cmd_err",   32'(cmd_err),   32'd0);
        chk("mid_rst_proto_err", 32'(proto_err), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        #1;
        chk("late_d_ready", 32'(bus.tlreq_d_ready), 32'd1);
        tick();
        bus.tlreq_d_valid = 1'b0;
        #1;
        chk("late_proto_err", 32'(proto_err), 32'd1);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
